// File: rtl/goertzel_sched_pkg.sv
// Shared definitions for the Goertzel run scheduler.
//   sched_state_t : scheduler FSM states
//   DW_DEF/RW_DEF : default coefficient/magnitude width and run-index width
//   clamp_runs()  : maps a requested run-pair count into 1..max_runs
package goertzel_sched_pkg;

    localparam int unsigned DW_DEF = 16;
    localparam int unsigned RW_DEF = 5;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BANK,
        REQ,
        WAIT_COEFF,
        START,
        WAIT_ENG,
        EMIT,
        ERR
    } sched_state_t;

    // A frame always holds at least one run pair.
    function automatic int unsigned clamp_runs(input int unsigned n,
                                               input int unsigned max_runs);
        if (n == 0) begin
            return 1;
        end else if (n > max_runs) begin
            return max_runs;
        end else begin
            return n;
        end
    endfunction

endpackage

// File: rtl/goertzel_sched_wdt.sv
// Handshake watchdog for the Goertzel run scheduler.
//   clk     : clock
//   rst     : synchronous reset, active-high
//   clr     : clear the count to zero
//   cnt     : count this cycle
//   expired : high in the counting cycle whose increment would reach TIMEOUT_CYC
module goertzel_sched_wdt #(
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic cnt,
    output logic expired
);

    localparam int unsigned WW = $clog2(TIMEOUT_CYC + 1);

    logic [WW-1:0] count;

    // Saturates at TIMEOUT_CYC so a stalled count can never wrap back to zero.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (cnt && (count != WW'(TIMEOUT_CYC))) begin
            count <= count + WW'(1);
        end
    end

    // Flagged one cycle early so the wait state lasts exactly TIMEOUT_CYC cycles.
    assign expired = cnt && (count == WW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/goertzel_run_scheduler.sv
// Sequences the dual Goertzel datapath across a frame of bin-pair runs.
// Each bank_ready starts one run pair: request coefficients, load and start
// the engine, then publish both magnitudes tagged with the run index.
//   sys_clk, sys_rst          : clock, synchronous active-high reset
//   enable                    : scheduler run enable
//   num_runs                  : run pairs per frame (sampled at frame start)
//   bank_ready                : new ADC sample bank pulse
//   coeff_req / coeff_ready   : coefficient handshake, coeff_sin/coeff_cos in
//   eng_sin/eng_cos/eng_start : latched coefficients and engine start
//   eng_done/eng_mag0/1       : engine completion and magnitudes
//   res_valid/res_run/res_mag0/1, frame_done : published results
//   busy, overrun, timeout_err: status (overrun and timeout_err are sticky)
module goertzel_run_scheduler
    import goertzel_sched_pkg::*;
#(
    parameter int unsigned DW          = DW_DEF,
    parameter int unsigned RW          = RW_DEF,
    parameter int unsigned MAX_RUNS    = 16,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          enable,
    input  logic [RW-1:0] num_runs,
    input  logic          bank_ready,
    output logic          coeff_req,
    input  logic          coeff_ready,
    input  logic [DW-1:0] coeff_sin,
    input  logic [DW-1:0] coeff_cos,
    output logic [DW-1:0] eng_sin,
    output logic [DW-1:0] eng_cos,
    output logic          eng_start,
    input  logic          eng_done,
    input  logic [DW-1:0] eng_mag0,
    input  logic [DW-1:0] eng_mag1,
    output logic          res_valid,
    output logic [RW-1:0] res_run,
    output logic [DW-1:0] res_mag0,
    output logic [DW-1:0] res_mag1,
    output logic          frame_done,
    output logic          busy,
    output logic          overrun,
    output logic          timeout_err
);

    sched_state_t  state;
    logic [RW-1:0] run_idx;
    logic [RW-1:0] runs_lat;
    logic          waiting;
    logic          wdt_clr;
    logic          wdt_expired;

    assign waiting = (state == WAIT_COEFF) || (state == WAIT_ENG);
    assign wdt_clr = !waiting;

    goertzel_sched_wdt #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_wdt (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .clr     (wdt_clr),
        .cnt     (waiting),
        .expired (wdt_expired)
    );

    // Outputs are registered on the transition into the state that owns them,
    // so each strobe is high exactly while the FSM sits in that state.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= IDLE;
            run_idx     <= '0;
            runs_lat    <= '0;
            coeff_req   <= 1'b0;
            eng_sin     <= '0;
            eng_cos     <= '0;
            eng_start   <= 1'b0;
            res_valid   <= 1'b0;
            res_run     <= '0;
            res_mag0    <= '0;
            res_mag1    <= '0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            coeff_req  <= 1'b0;
            eng_start  <= 1'b0;
            res_valid  <= 1'b0;
            frame_done <= 1'b0;

            if (bank_ready && (state != IDLE) && (state != WAIT_BANK)) begin
                overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    run_idx <= '0;
                    if (enable) begin
                        state <= WAIT_BANK;
                    end
                end

                WAIT_BANK: begin
                    if (!enable) begin
                        state   <= IDLE;
                        run_idx <= '0;
                    end else if (bank_ready) begin
                        state     <= REQ;
                        coeff_req <= 1'b1;
                        busy      <= 1'b1;
                        if (run_idx == '0) begin
                            runs_lat <= RW'(clamp_runs(32'(num_runs), MAX_RUNS));
                        end
                    end
                end

                REQ: begin
                    state <= WAIT_COEFF;
                end

                WAIT_COEFF: begin
                    if (coeff_ready) begin
                        state     <= START;
                        eng_sin   <= coeff_sin;
                        eng_cos   <= coeff_cos;
                        eng_start <= 1'b1;
                    end else if (wdt_expired) begin
                        state       <= ERR;
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                    end
                end

                START: begin
                    state <= WAIT_ENG;
                end

                WAIT_ENG: begin
                    if (eng_done) begin
                        state      <= EMIT;
                        res_mag0   <= eng_mag0;
                        res_mag1   <= eng_mag1;
                        res_run    <= run_idx;
                        res_valid  <= 1'b1;
                        frame_done <= (run_idx == runs_lat - RW'(1));
                    end else if (wdt_expired) begin
                        state       <= ERR;
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                    end
                end

                EMIT: begin
                    busy <= 1'b0;
                    // frame_done already holds the last-run compare for this pair.
                    if (!enable) begin
                        state   <= IDLE;
                        run_idx <= '0;
                    end else begin
                        state <= WAIT_BANK;
                        if (frame_done) begin
                            run_idx <= '0;
                        end else begin
                            run_idx <= run_idx + RW'(1);
                        end
                    end
                end

                ERR: begin
                    if (!enable) begin
                        state   <= IDLE;
                        run_idx <= '0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
